// File: rtl/sigmoid_arbiter_if.sv
// Requester-side bundle for the shared sigmoid unit: per-requester request handshake and operands,
// plus the one-hot response strobe and the shared response data word.
// The arbiter uses the slave modport; the neuron accumulators use the master modport.
interface sigmoid_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ*32-1:0] req_data;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ-1:0]    rsp_valid;
   logic [31:0]           rsp_data;

   modport master (
      output req_valid, req_data,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_data,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/sigmoid_arbiter.sv
// Round-robin sharing of one combinational Q16.16 sigmoid among NUM_REQ requesters (piecewise-linear fit).
// Latency: handshake to one-hot rsp_valid is exactly PIPE_STAGES cycles; one operand accepted per cycle.
// Backpressure: none on responses; grants stop only when enable=0. SIGMOID_SAT_STATS_EN adds sat_clr/sat_count.
module sigmoid_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int PIPE_STAGES = 2
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             enable,
   sigmoid_arbiter_if.slave                 bus,
`ifdef SIGMOID_SAT_STATS_EN
   input  logic                             sat_clr,
   output logic [15:0]                      sat_count,
`endif
   output logic                             busy,
   output logic [$clog2(PIPE_STAGES+1)-1:0] inflight_count
);
   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(PIPE_STAGES+1);

   logic [IDX_W-1:0]       last_grant_q, last_grant_d;
   logic [IDX_W-1:0]       grant_idx;
   logic [NUM_REQ-1:0]     grant;
   logic [31:0]            grant_dat;
   logic                   hs;
   logic [PIPE_STAGES-1:0] vld_q;
   logic [IDX_W-1:0]       idx_q [PIPE_STAGES];
   logic [31:0]            op_q;
   logic [31:0]            sig_res;
   logic [31:0]            out_dat;
`ifdef SIGMOID_SAT_STATS_EN
   logic [31:0]            out_op;
`endif

   // Piecewise-linear sigmoid: slopes 1/4, 1/8, 1/32 with breakpoints at 1.0, 2.375, 5.0; odd symmetry about 0.5.
   function automatic logic [31:0] sigmoid(input logic [31:0] x);
      logic [31:0] a;
      logic [31:0] y;
      a = x[31] ? (~x + 32'd1) : x;
      if (a >= 32'h0005_0000)      y = 32'h0001_0000;
      else if (a >= 32'h0002_6000) y = (a >> 5) + 32'h0000_D800;
      else if (a >= 32'h0001_0000) y = (a >> 3) + 32'h0000_A000;
      else                         y = (a >> 2) + 32'h0000_8000;
      return x[31] ? (32'h0001_0000 - y) : y;
   endfunction

   // Search upward from last_grant+1, wrapping once over every requester; no grant while disabled or in reset.
   always_comb begin
      int               cand;
      logic [IDX_W-1:0] cidx;
      logic             found;
      grant     = '0;
      grant_idx = last_grant_q;
      grant_dat = '0;
      found     = 1'b0;
      cand      = 0;
      cidx      = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = int'(last_grant_q) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         cidx = cand[IDX_W-1:0];
         if (!found && enable && rst_n && bus.req_valid[cidx]) begin
            found       = 1'b1;
            grant[cidx] = 1'b1;
            grant_idx   = cidx;
            grant_dat   = bus.req_data[32*cidx +: 32];
         end
      end
   end

   assign bus.req_ready = grant;
   assign hs            = |grant;
   assign last_grant_d  = hs ? grant_idx : last_grant_q;

   // Priority pointer advances only on an accepted handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_grant_q <= IDX_W'(NUM_REQ-1);
      else        last_grant_q <= last_grant_d;
   end

   // Stage 1 captures the accepted operand; later stages shift valid and requester index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         op_q  <= '0;
         for (int k = 0; k < PIPE_STAGES; k++) idx_q[k] <= '0;
      end else begin
         vld_q[0] <= hs;
         if (hs) begin
            idx_q[0] <= grant_idx;
            op_q     <= grant_dat;
         end
         for (int k = 1; k < PIPE_STAGES; k++) begin
            vld_q[k] <= vld_q[k-1];
            if (vld_q[k-1]) idx_q[k] <= idx_q[k-1];
         end
      end
   end

   assign sig_res = sigmoid(op_q);

   generate
      if (PIPE_STAGES == 1) begin : g_p1
         logic seen_q;
         // Output reads zero until a first result exists, rather than sigmoid of the reset operand.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)      seen_q <= 1'b0;
            else if (vld_q[0]) seen_q <= 1'b1;
         end
         assign out_dat = seen_q ? sig_res : '0;
`ifdef SIGMOID_SAT_STATS_EN
         assign out_op = op_q;
`endif
      end else begin : g_pn
         logic [31:0] res_q [1:PIPE_STAGES-1];
`ifdef SIGMOID_SAT_STATS_EN
         logic [31:0] opc_q [1:PIPE_STAGES-1];
`endif
         // Result (and the original operand when stats are on) moves only with a valid entry, so stale data holds.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int k = 1; k < PIPE_STAGES; k++) begin
                  res_q[k] <= '0;
`ifdef SIGMOID_SAT_STATS_EN
                  opc_q[k] <= '0;
`endif
               end
            end else begin
               if (vld_q[0]) begin
                  res_q[1] <= sig_res;
`ifdef SIGMOID_SAT_STATS_EN
                  opc_q[1] <= op_q;
`endif
               end
               for (int k = 2; k < PIPE_STAGES; k++) begin
                  if (vld_q[k-1]) begin
                     res_q[k] <= res_q[k-1];
`ifdef SIGMOID_SAT_STATS_EN
                     opc_q[k] <= opc_q[k-1];
`endif
                  end
               end
            end
         end
         assign out_dat = res_q[PIPE_STAGES-1];
`ifdef SIGMOID_SAT_STATS_EN
         assign out_op = opc_q[PIPE_STAGES-1];
`endif
      end
   endgenerate

   // One-hot response strobe decoded from the final stage's requester index.
   always_comb begin
      bus.rsp_valid = '0;
      if (vld_q[PIPE_STAGES-1]) bus.rsp_valid[idx_q[PIPE_STAGES-1]] = 1'b1;
   end

   assign bus.rsp_data = out_dat;

   // Occupancy is the number of live stage-valid bits.
   always_comb begin
      inflight_count = '0;
      for (int k = 0; k < PIPE_STAGES; k++) inflight_count = inflight_count + CNT_W'(vld_q[k]);
   end

   assign busy = |vld_q;

`ifdef SIGMOID_SAT_STATS_EN
   logic [15:0] sat_q;
   logic [31:0] out_abs;
   logic        out_sat;

   assign out_abs = out_op[31] ? (~out_op + 32'd1) : out_op;
   assign out_sat = vld_q[PIPE_STAGES-1] && (out_abs >= 32'h0005_0000);

   // Count retiring saturated-region operands; clear beats increment and the count sticks at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          sat_q <= '0;
      else if (sat_clr)                    sat_q <= '0;
      else if (out_sat && sat_q != 16'hFFFF) sat_q <= sat_q + 16'd1;
   end

   assign sat_count = sat_q;
`endif
endmodule

// File: tb/tb_sigmoid_arbiter.sv
// Self-checking bench for sigmoid_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level model (grant search, response queue, occupancy).
// Build with or without SIGMOID_SAT_STATS_EN.
module tb_sigmoid_arbiter;
   localparam int N = 4;
   localparam int P = 2;

   typedef struct {
      int          due;
      int          idx;
      logic [31:0] op;
   } ent_t;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic                     enable = 1'b0;
   logic                     busy;
   logic [$clog2(P+1)-1:0]   inflight_count;
`ifdef SIGMOID_SAT_STATS_EN
   logic                     sat_clr = 1'b0;
   logic [15:0]              sat_count;
`endif

   sigmoid_arbiter_if #(.NUM_REQ(N)) bus ();

   sigmoid_arbiter #(.NUM_REQ(N), .PIPE_STAGES(P)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .enable         (enable),
      .bus            (bus),
`ifdef SIGMOID_SAT_STATS_EN
      .sat_clr        (sat_clr),
      .sat_count      (sat_count),
`endif
      .busy           (busy),
      .inflight_count (inflight_count)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   ent_t        q[$];
   int          last_g;
   int          cyc;
   logic [31:0] m_rsp;
   int          m_sat;
   logic [N-1:0] rv;
   logic [31:0] rd [N];
   logic [31:0] o_ready, o_rsp_v, o_rsp_d, o_cnt, o_busy, o_sat;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Reference sigmoid from its breakpoint table: 0.5+x/4, 0.625+x/8, 0.84375+x/32, 1.0; mirrored for x<0.
   function automatic logic [31:0] ref_sig(input logic [31:0] x);
      longint ax, y;
      ax = x[31] ? ((longint'(1) << 32) - longint'(x)) : longint'(x);
      if (ax >= 5 * 65536)          y = 65536;
      else if (ax >= 65536 * 19 / 8) y = ax / 32 + 65536 * 27 / 32;
      else if (ax >= 65536)         y = ax / 8 + 65536 * 5 / 8;
      else                          y = ax / 4 + 65536 / 2;
      if (x[31]) y = 65536 - y;
      return y[31:0];
   endfunction

   function automatic bit is_sat(input logic [31:0] x);
      longint ax;
      ax = x[31] ? ((longint'(1) << 32) - longint'(x)) : longint'(x);
      return ax >= 5 * 65536;
   endfunction

   function automatic int oh2i(input logic [31:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic logic [31:0] rnd_op();
      logic [31:0] edges [8];
      edges = '{32'h0005_0000, 32'hFFFB_0000, 32'h0004_FFFF, 32'hFFFB_0001,
                32'h0002_6000, 32'h0001_0000, 32'h0000_FFFF, 32'h8000_0000};
      case ($urandom_range(0, 3))
         0:       return 32'($urandom_range(0, 32'h000A_0000)) - 32'h0005_0000;
         1:       return 32'($urandom_range(0, 32'h0010_0000)) - 32'h0008_0000;
         2:       return $urandom();
         default: return edges[$urandom_range(0, 7)];
      endcase
   endfunction

   task automatic apply();
      logic [32*N-1:0] d;
      for (int i = 0; i < N; i++) d[32*i +: 32] = rd[i];
      bus.req_valid = rv;
      bus.req_data  = d;
   endtask

   // One clock cycle: compare every output against the model at the falling edge, then advance the model.
   task automatic step(output int g);
      logic [N-1:0] er, ev;
      logic [31:0]  ed;
      int           cnt;
      bit           ret_sat;
      ent_t         e;
      @(negedge clk);
      if (!rst_n) begin
         q.delete();
         last_g = N - 1;
         m_rsp  = '0;
         m_sat  = 0;
      end
      er = '0;
      g  = -1;
      if (enable && rst_n)
         for (int k = 1; k <= N; k++)
            if (g < 0 && bus.req_valid[(last_g + k) % N]) g = (last_g + k) % N;
      if (g >= 0) er[g] = 1'b1;
      ev = '0; ed = m_rsp; cnt = 0; ret_sat = 0;
      foreach (q[i]) begin
         if (q[i].due >= cyc) cnt++;
         if (q[i].due == cyc) begin
            ev[q[i].idx] = 1'b1;
            ed           = ref_sig(q[i].op);
            ret_sat      = is_sat(q[i].op);
         end
      end
      o_ready = 32'(bus.req_ready);
      o_rsp_v = 32'(bus.rsp_valid);
      o_rsp_d = bus.rsp_data;
      o_cnt   = 32'(inflight_count);
      o_busy  = 32'(busy);
      chk("req_ready", o_ready, 32'(er));
      chk("rsp_valid", o_rsp_v, 32'(ev));
      chk("rsp_data", o_rsp_d, ed);
      chk("inflight_count", o_cnt, 32'(cnt));
      chk("busy", o_busy, 32'(cnt != 0));
`ifdef SIGMOID_SAT_STATS_EN
      o_sat = 32'(sat_count);
      chk("sat_count", o_sat, 32'(m_sat));
      if (sat_clr)                       m_sat = 0;
      else if (ret_sat && m_sat < 65535) m_sat++;
`else
      o_sat = '0;
`endif
      m_rsp = ed;
      while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
      if (g >= 0) begin
         e.due = cyc + P;
         e.idx = g;
         e.op  = rd[g];
         q.push_back(e);
         last_g = g;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      int g;
      rst_n = 1'b0;
      rv    = '0;
      apply();
      step(g);
      rst_n = 1'b1;
   endtask

   initial begin
      int g;
      int gs[$];
      cyc    = 0;
      last_g = N - 1;
      m_rsp  = '0;
      m_sat  = 0;
      rv     = '0;
      for (int i = 0; i < N; i++) rd[i] = '0;
      apply();

      // Reset values
      step(g);
      step(g);
      chk("rst_busy", o_busy, 32'd0);
      rst_n  = 1'b1;
      enable = 1'b1;

      // Single request: sigmoid(0) = 0.5 two cycles after the grant
      rv = 4'b0001; rd[0] = 32'h0; apply();
      step(g);
      chk("single_grant", o_ready, 32'h1);
      rv = '0; apply();
      step(g);
      step(g);
      chk("single_rsp_valid", o_rsp_v, 32'h1);
      chk("single_rsp_data", o_rsp_d, 32'h0000_8000);

      // Round-robin with all four requesting
      do_reset();
      rv = '1;
      for (int i = 0; i < N; i++) rd[i] = rnd_op();
      apply();
      for (int i = 0; i < 8; i++) begin
         step(g);
         gs.push_back(oh2i(o_ready));
         if (g >= 0) rd[g] = rnd_op();
         apply();
      end
      for (int i = 0; i < 8; i++) chk("rr_order", 32'(gs[i]), 32'(i % N));
      rv = '0; apply();
      for (int i = 0; i < 3; i++) step(g);

      // Enable gating with two entries in flight
      rv = '1; apply();
      step(g);
      rd[g] = rnd_op(); apply();
      step(g);
      enable = 1'b0; apply();
      step(g);
      chk("en_cnt2", o_cnt, 32'd2);
      chk("en_noready", o_ready, 32'd0);
      step(g);
      chk("en_cnt1", o_cnt, 32'd1);
      chk("en_busy_last", o_busy, 32'd1);
      step(g);
      chk("en_cnt0", o_cnt, 32'd0);
      chk("en_busy_fall", o_busy, 32'd0);
      enable = 1'b1;

      // Reset mid-stream discards in-flight entries; requester 1 wins first afterwards
      step(g);
      step(g);
      rst_n = 1'b0; apply();
      step(g);
      chk("rstmid_rsp", o_rsp_v, 32'd0);
      rst_n = 1'b1;
      rv = 4'b1010; apply();
      step(g);
      chk("rstmid_grant", o_ready, 32'b0010);
      chk("rstmid_rsp2", o_rsp_v, 32'd0);
      rv = '0; apply();
      for (int i = 0; i < 3; i++) step(g);

      // Sparse pointer: requester 3 first, then 0 via wrap
      do_reset();
      rv = 4'b1000; apply();
      step(g);
      chk("sparse_r3", o_ready, 32'b1000);
      rv = 4'b0001; apply();
      step(g);
      chk("sparse_r0", o_ready, 32'b0001);
      rv = '0; apply();
      for (int i = 0; i < 3; i++) step(g);

`ifdef SIGMOID_SAT_STATS_EN
      // Saturation statistics and clear-wins-over-increment
      do_reset();
      rv = 4'b0100; rd[2] = 32'h0006_0000; apply();
      step(g);
      rv = '0; apply();
      step(g);
      step(g);
      chk("sat_rsp_data", o_rsp_d, 32'h0001_0000);
      step(g);
      chk("sat_count1", o_sat, 32'd1);
      rv = 4'b0100; rd[2] = 32'hFFFA_0000; apply();
      step(g);
      rv = '0; apply();
      step(g);
      sat_clr = 1'b1;
      step(g);
      chk("sat_neg_rsp", o_rsp_d, 32'h0);
      sat_clr = 1'b0;
      step(g);
      chk("sat_clear_wins", o_sat, 32'd0);
`endif

      // Randomized traffic with withdrawals, enable toggling and occasional resets
      g = -1;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (g == i) begin
               rd[i] = rnd_op();
               rv[i] = 1'($urandom_range(0, 1));
            end else if (rv[i]) begin
               if ($urandom_range(0, 9) == 0) rv[i] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
               rv[i] = 1'b1;
               rd[i] = rnd_op();
            end
         end
         enable = ($urandom_range(0, 9) != 0);
         rst_n  = ($urandom_range(0, 299) != 0);
`ifdef SIGMOID_SAT_STATS_EN
         sat_clr = ($urandom_range(0, 19) == 0);
`endif
         apply();
         step(g);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
